fft_output_unloader: RTL
========================

Name: fft_output_unloader

Overview:
- Downstream neighbour of the 64-point radix-2 DIF in-place control block.
- After the last butterfly stage, it reads the finished frame from the two 32-word dual-port banks (bank0 and bank1) through their read ports.
- It undoes the DIF bit-reversed ordering and streams X[0..63] in natural order on a valid/ready interface.
- It owns the bank read ports only while busy; an external mux gives it those ports during the input phase.

Parameters:
- DW, 32, bank word width (re/im packed, 16+16).
- N_LOG2, 6, log2 of the FFT length; this block supports only 6 (64 points, 32 words per bank).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- output_start  in  1  one-cycle pulse from the control block: frame complete in the banks
- re_b0  out  1  bank0 read enable
- raddr_b0  out  5  bank0 read address
- rdata_b0  in  DW  bank0 read data, valid the cycle after re_b0
- re_b1  out  1  bank1 read enable
- raddr_b1  out  5  bank1 read address
- rdata_b1  in  DW  bank1 read data, valid the cycle after re_b1
- dout  out  DW  output sample
- dout_valid  out  1  dout holds a valid sample
- dout_ready  in  1  downstream accepts the sample
- dout_idx  out  6  natural-order index of dout
- dout_last  out  1  high with index 63
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after the last handshake
- overrun  out  1  sticky flag: output_start arrived while busy; cleared only by rst

Behaviour:
- Reset values: all outputs are 0; FSM is IDLE; FIFO is empty; counters are 0. Reset mid-frame aborts immediately with no done pulse.
- FSM states: IDLE, READ, DRAIN.
  - IDLE -> READ on output_start.
  - READ -> DRAIN after read index 63 is issued.
  - DRAIN -> IDLE on the handshake of sample 63; done pulses in the following cycle.
- Read addressing for natural index n (6-bit read counter):
  - Stored position p = bitrev6(n).
  - Bank = parity(p): 0 selects bank0, 1 selects bank1.
  - Address = p[5:1].
  - Exactly one of re_b0/re_b1 is high per issued read. The unused address is driven to 0.
- A 1-bit register remembers which bank each in-flight read targets. The returned rdata is muxed by that bit.
- Output buffer: 2-entry FIFO carrying {data, idx}. dout_* come from the FIFO head, registered; no combinational path from dout_ready to dout.
- Read issue rule (credit-based): issue when fifo_count + inflight - pop < 2. This must sustain one sample per cycle with dout_ready held high, and must never overflow under any dout_ready pattern.
- Latency: output_start sampled at edge 0; first read issued in cycle 1; first dout_valid in cycle 3. With dout_ready constantly high, samples appear in cycles 3..66 and done pulses in cycle 67.
- Handshake: transfer when dout_valid && dout_ready. While dout_valid is high and the sample is not accepted, dout, dout_idx and dout_last are held stable.
- output_start while busy is ignored except for setting overrun; the frame in progress is unaffected. output_start in the same cycle as the done pulse is accepted (busy is low in that cycle).
- Read counter: 6-bit and stops at 63; no wrap-around reads.

Optional Feature:
- Macro: UNLOAD_NATURAL_ORDER_EN.
- Defined: bit-reversed addressing as specified above; natural-order output.
- Undefined: p = n, so samples stream in storage (bit-reversed) order and dout_idx reports bitrev6(n) of the raw counter. Bank/address derivation from p and all handshake and timing rules are unchanged.

Decomposition:
- Shared package fft_pkg:
  - constants FFT_N=64, FFT_LOG2=6, BANK_DEPTH=32, BANK_AW=5
  - functions bitrev6 and parity6
  - FSM state typedef
- One natural sub-module, fft_unload_fifo2: a 2-entry registered FIFO with count output. The FSM, address generation and credit logic stay in the top.

Test Plan:
- Banks preloaded so that word p holds value p (stored at bank parity(p), addr p[5:1]); pulse output_start; dout_ready=1 -> dout_idx 0..63 at cycles 3..66; dout=bitrev6(idx); dout_last only at idx 63; done in cycle 67.
- Same preload, dout_ready toggling 1,0,0,1 randomly -> identical 64-sample sequence, no drops or duplicates, outputs stable while stalled, at most 2 reads outstanding.
- Start busy; output_start pulsed at sample 20 -> overrun=1 and sticky; sample stream unchanged; second start not serviced.
- Reset asserted at sample 30 -> next cycle all outputs 0 and no done; a fresh output_start gives a full 64-sample frame.
- Back-to-back: output_start in the same cycle as done -> second frame starts, first read in the next cycle, overrun stays 0.
- Macro undefined -> dout_idx order 0,32,16,48,...; dout equals the raw storage order.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, index helpers and FSM state type for the FFT output unload path.
package fft_pkg;

  localparam int unsigned FFT_N      = 64;
  localparam int unsigned FFT_LOG2   = $clog2(FFT_N);
  localparam int unsigned BANK_DEPTH = FFT_N / 2;
  localparam int unsigned BANK_AW    = $clog2(BANK_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } unload_state_t;

  // Reverse the bit order of a 6-bit index.
  function automatic logic [5:0] bitrev6(input logic [5:0] v);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[i] = v[5-i];
    end
    return r;
  endfunction

  // Even parity of a 6-bit index; selects the bank holding that storage position.
  function automatic logic parity6(input logic [5:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/fft_unload_fifo2.sv
// Two-entry FIFO with registered head and occupancy count, buffering returned bank reads.
module fft_unload_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         head_valid,
  output logic [1:0]   count
);

  logic [W-1:0] slot1;
  logic [W-1:0] head_nxt;
  logic [W-1:0] slot1_nxt;
  logic [1:0]   count_nxt;

  // Head only changes on a pop or when written into an empty FIFO, so it holds while stalled.
  always_comb begin
    head_nxt  = head;
    slot1_nxt = slot1;
    count_nxt = count;
    case ({push, pop})
      2'b10: begin
        if (count == 2'd0) begin
          head_nxt = push_data;
        end else begin
          slot1_nxt = push_data;
        end
        count_nxt = count + 2'd1;
      end
      2'b01: begin
        head_nxt  = slot1;
        count_nxt = count - 2'd1;
      end
      2'b11: begin
        if (count == 2'd1) begin
          head_nxt = push_data;
        end else begin
          head_nxt  = slot1;
          slot1_nxt = push_data;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      slot1      <= '0;
      count      <= 2'd0;
      head_valid <= 1'b0;
    end else begin
      head       <= head_nxt;
      slot1      <= slot1_nxt;
      count      <= count_nxt;
      head_valid <= (count_nxt != 2'd0);
    end
  end

endmodule

// File: rtl/fft_output_unloader.sv
// Reads a finished 64-point DIF frame out of the two result banks and streams it on valid/ready.
// UNLOAD_NATURAL_ORDER_EN: defined -> natural-order output; undefined -> storage (bit-reversed) order.
module fft_output_unloader
  import fft_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned N_LOG2 = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                output_start,
  output logic                re_b0,
  output logic [BANK_AW-1:0]  raddr_b0,
  input  logic [DW-1:0]       rdata_b0,
  output logic                re_b1,
  output logic [BANK_AW-1:0]  raddr_b1,
  input  logic [DW-1:0]       rdata_b1,
  output logic [DW-1:0]       dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [FFT_LOG2-1:0] dout_idx,
  output logic                dout_last,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  localparam int unsigned   IW       = FFT_LOG2;
  localparam int unsigned   PW       = DW + IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'((1 << N_LOG2) - 1);

  unload_state_t state;
  unload_state_t state_nxt;
  logic          done_nxt;

  logic [IW-1:0]      rd_cnt;
  logic [IW-1:0]      rd_pos;
  logic [IW-1:0]      out_idx;
  logic               rd_bank;
  logic [BANK_AW-1:0] rd_addr;
  logic               rd_is_last;

  logic               inflight;
  logic               inflight_bank;
  logic [IW-1:0]      inflight_idx;
  logic               inflight_last;

  logic [1:0]         fifo_count;
  logic [PW-1:0]      fifo_head;
  logic               fifo_valid;
  logic [PW-1:0]      push_data;
  logic               pop;
  logic [2:0]         credit;
  logic               issue;

  // Storage position and reported index for the current read counter.
`ifdef UNLOAD_NATURAL_ORDER_EN
  assign rd_pos  = bitrev6(rd_cnt);
  assign out_idx = rd_cnt;
`else
  assign rd_pos  = rd_cnt;
  assign out_idx = bitrev6(rd_cnt);
`endif

  assign rd_bank    = parity6(rd_pos);
  assign rd_addr    = rd_pos[IW-1:1];
  assign rd_is_last = (rd_cnt == LAST_IDX);

  // Credit check: buffered + in-flight samples, less the one leaving now, must leave room.
  assign pop    = fifo_valid && dout_ready;
  assign credit = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign issue  = (state == ST_READ) && (credit < 3'd2);

  always_comb begin
    re_b0    = 1'b0;
    re_b1    = 1'b0;
    raddr_b0 = '0;
    raddr_b1 = '0;
    if (issue) begin
      if (rd_bank) begin
        re_b1    = 1'b1;
        raddr_b1 = rd_addr;
      end else begin
        re_b0    = 1'b1;
        raddr_b0 = rd_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (output_start) begin
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (issue && rd_is_last) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && dout_last) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Read counter saturates at the last index; the tag registers follow each issued read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_bank <= 1'b0;
      inflight_idx  <= '0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_bank <= rd_bank;
        inflight_idx  <= out_idx;
        inflight_last <= rd_is_last;
      end
      if ((state == ST_IDLE) && output_start) begin
        rd_cnt <= '0;
      end else if (issue && !rd_is_last) begin
        rd_cnt <= rd_cnt + IW'(1);
      end
      busy <= (state_nxt != ST_IDLE);
      done <= done_nxt;
      if (output_start && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

  assign push_data = {(inflight_bank ? rdata_b1 : rdata_b0), inflight_idx, inflight_last};

  fft_unload_fifo2 #(
    .W (PW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight),
    .push_data  (push_data),
    .pop        (pop),
    .head       (fifo_head),
    .head_valid (fifo_valid),
    .count      (fifo_count)
  );

  assign dout       = fifo_head[PW-1 -: DW];
  assign dout_idx   = fifo_head[IW:1];
  assign dout_last  = fifo_head[0];
  assign dout_valid = fifo_valid;

endmodule
